// File: rtl/rd_port_arbiter.sv
// rd_port_arbiter: round-robin burst arbiter for an async FIFO read port.
// The popped words return through a 2-entry skid buffer, each tagged with the id of the consumer that requested it.
module rd_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  input  logic              empty,
  output logic              r_en,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] o_data,
  output logic [ID_W-1:0]   o_id,
  output logic              o_valid,
  input  logic              o_ready
);
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t            state;
  logic [ID_W-1:0]   g, last, pick, k, tag;
  logic [CW-1:0]     burst_cnt;
  logic              inflight, hd, deq, space, pop, last_pop;
  logic [1:0]        occ;
  logic [DATA_W-1:0] sd [2];
  logic [ID_W-1:0]   sid [2];
  assign o_valid  = occ != 2'd0;
  assign o_data   = sd[hd];
  assign o_id     = sid[hd];
  assign deq      = o_valid & o_ready;
  // A word in flight already owns a buffer slot, so it is counted as if it were stored.
  assign space    = ({1'b0, occ} + {2'b0, inflight} - {2'b0, deq}) < 3'd2;
  assign pop      = (state == BURST) & req[g] & ~empty & space;
  assign r_en     = pop;
  assign last_pop = pop && (burst_cnt == CW'(BURST_LEN - 1));
  // Scan downward so that the nearest requester after last overwrites the others.
  always_comb begin
    pick = last;
    k = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = ID_W'((int'(last) + i) % N_REQ);
      if (req[k]) pick = k;
    end
  end
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state     <= IDLE;
      gnt       <= '0;
      g         <= '0;
      last      <= ID_W'(N_REQ - 1);
      burst_cnt <= '0;
      inflight  <= 1'b0;
      tag       <= '0;
      occ       <= 2'd0;
      hd        <= 1'b0;
      sd[0]     <= '0;
      sd[1]     <= '0;
      sid[0]    <= '0;
      sid[1]    <= '0;
    end else begin
      inflight <= pop;
      if (pop) tag <= g;
      if (state == IDLE) begin
        if (|req) begin
          state <= BURST;
          g     <= pick;
          gnt   <= N_REQ'(1) << pick;
        end
      end else if (last_pop || !req[g]) begin
        state     <= IDLE;
        gnt       <= '0;
        last      <= g;
        burst_cnt <= '0;
      end else if (pop) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (inflight) begin
        sd[hd ^ occ[0]]  <= rdata;
        sid[hd ^ occ[0]] <= tag;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, deq};
      if (deq) hd <= ~hd;
    end
  end
endmodule

// File: tb/tb_rd_port_arbiter.sv
// tb_rd_port_arbiter: randomized scoreboard bench with a transaction-level arbiter/buffer reference model.
module tb_rd_port_arbiter;
  localparam int N = 4, W = 8, BL = 4;
  logic         rclk = 1'b0, rrst = 1'b1;
  logic [N-1:0] req = '0, gnt;
  logic         empty = 1'b1, r_en, o_valid, o_ready = 1'b0;
  logic [W-1:0] rdata = '0, o_data;
  logic [1:0]   o_id;

  rd_port_arbiter #(.N_REQ(N), .DATA_W(W), .BURST_LEN(BL), .ID_W(2)) dut (
    .rclk(rclk), .rrst(rrst), .req(req), .gnt(gnt), .empty(empty), .r_en(r_en),
    .rdata(rdata), .o_data(o_data), .o_id(o_id), .o_valid(o_valid), .o_ready(o_ready)
  );

  always #5 rclk = ~rclk;

  typedef struct {int id; int data;} exp_t;
  exp_t exp_q[$];
  int   fifo_q[$];
  int   pend[$];
  int   tests = 0, fails = 0;
  int   m_owner = -1, m_cnt = 0, m_last = N - 1, cyc = 0, next_word = 0;
  int   p_flip = 0, p_ready = 100, p_push = 0, p_gap = 0, p_rst = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: words popped but not yet accepted are outstanding; at most 2 may remain after any cycle.
  task automatic model_step();
    bit ev, acc, sp, pop;
    ev  = pend.size() > 0 && pend[0] <= cyc - 2;
    acc = ev && o_ready;
    sp  = (pend.size() - int'(acc)) < 2;
    pop = m_owner >= 0 && req[m_owner] && !empty && sp;
    chk("gnt", int'(gnt), m_owner < 0 ? 0 : (1 << m_owner));
    chk("r_en", int'(r_en), int'(pop));
    chk("o_valid", int'(o_valid), int'(ev));
    if (acc) void'(pend.pop_front());
    if (pop) begin
      pend.push_back(cyc);
      exp_q.push_back('{m_owner, fifo_q[0]});
    end
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++)
        if (req[(m_last + i) % N]) begin
          m_owner = (m_last + i) % N;
          m_cnt = 0;
          break;
        end
    end else begin
      if (pop) m_cnt++;
      if (m_cnt == BL || !req[m_owner]) begin
        m_last = m_owner;
        m_owner = -1;
        m_cnt = 0;
      end
    end
    cyc++;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      next_word = (next_word + 37) % 256;
    end
    empty = fifo_q.size() == 0;
  endtask

  task automatic cycle();
    bit ren_s;
    @(negedge rclk);
    model_step();
    ren_s = r_en;
    @(posedge rclk);
    #1;
    if (ren_s && fifo_q.size() > 0) rdata = W'(fifo_q.pop_front());
    if ($urandom_range(99) < p_push) fill(1);
    for (int i = 0; i < N; i++) if ($urandom_range(99) < p_flip) req[i] = ~req[i];
    o_ready = $urandom_range(99) < p_ready;
    empty = ($urandom_range(99) < p_gap) || fifo_q.size() == 0;
  endtask

  task automatic do_reset();
    #1;
    rrst = 1'b1;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_r_en", int'(r_en), 0);
    chk("rst_o_data", int'(o_data), 0);
    chk("rst_o_id", int'(o_id), 0);
    exp_q.delete();
    pend.delete();
    m_owner = -1;
    m_cnt = 0;
    m_last = N - 1;
    @(posedge rclk);
    #1;
    rrst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (p_rst > 0 && $urandom_range(999) < p_rst) do_reset();
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge rclk);
      if (!rrst && o_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL o_word: unexpected word id=%0d data=%0d, none required", o_id, o_data);
        end else begin
          chk("o_id", int'(o_id), exp_q[0].id);
          chk("o_data", int'(o_data), exp_q[0].data);
          if (o_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    #3;
    chk("init_gnt", int'(gnt), 0);
    chk("init_o_valid", int'(o_valid), 0);
    chk("init_r_en", int'(r_en), 0);
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    req = 4'b0010;
    fill(3);
    run(15);
    req = 4'b1111;
    fill(16);
    run(30);
    req = 4'b0001;
    fill(8);
    p_ready = 0;
    run(10);
    p_ready = 100;
    run(15);
    req = 4'b1111;
    fill(8);
    p_ready = 0;
    run(6);
    do_reset();
    p_ready = 100;
    run(12);
    req = 4'b0100;
    fill(2);
    run(5);
    p_gap = 100;
    empty = 1'b1;
    run(5);
    p_gap = 0;
    fill(4);
    run(10);
    for (int ph = 0; ph < 6; ph++) begin
      p_flip  = 2 + 6 * (ph % 3);
      p_ready = 30 + 14 * ph;
      p_push  = 40 + 10 * (ph % 4);
      p_gap   = 10 * (ph % 3);
      p_rst   = 2;
      run(400);
    end
    p_rst = 0;
    p_flip = 0;
    p_gap = 0;
    p_push = 0;
    p_ready = 100;
    req = '0;
    run(12);
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
